// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, bubble-inserting flush,
// optional 2-entry skid buffer and a saturating starvation counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [CNT_W-1:0]  bubbleCount
);

    logic              in_ready_w;
    logic              in_fire;
    logic              out_fire;
    logic              out_valid_q;
    logic [DATA_W-1:0] head_data_q;
    logic [CTRL_W-1:0] head_ctrl_q;
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  bubble_d;

    assign in_fire     = inValid & in_ready_w;
    assign out_fire    = out_valid_q & outReady;
    assign inReady     = in_ready_w;
    assign outValid    = out_valid_q;
    assign outData     = head_data_q;
    // Gate control so a bubble always looks like a NOP downstream.
    assign outCtrl     = out_valid_q ? head_ctrl_q : '0;
    assign bubbleCount = bubble_q;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t            state_q, state_d;
            logic              in_ready_q, in_ready_d;
            logic              out_valid_d;
            logic [DATA_W-1:0] head_data_d, skid_data_q, skid_data_d;
            logic [CTRL_W-1:0] head_ctrl_d, skid_ctrl_q, skid_ctrl_d;

            // The flop holds "not FULL"; the reset term keeps inReady low during reset.
            assign in_ready_w = reset & in_ready_q;

            always_comb begin
                // NOTE: every signal gets a default first, so no path can infer a latch.
                state_d     = state_q;
                head_data_d = head_data_q;
                head_ctrl_d = head_ctrl_q;
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d     = ONE;
                            head_data_d = inData;
                            head_ctrl_d = inCtrl;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            head_data_d = inData;
                            head_ctrl_d = inCtrl;
                        end else if (in_fire) begin
                            state_d     = FULL;
                            skid_data_d = inData;
                            skid_ctrl_d = inCtrl;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            state_d     = ONE;
                            head_data_d = skid_data_q;
                            head_ctrl_d = skid_ctrl_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                // Flush drops everything; payload registers keep their old contents.
                if (flush) begin
                    state_d     = EMPTY;
                    head_data_d = head_data_q;
                    head_ctrl_d = head_ctrl_q;
                    skid_data_d = skid_data_q;
                    skid_ctrl_d = skid_ctrl_q;
                end
                out_valid_d = (state_d != EMPTY);
                in_ready_d  = (state_d != FULL);
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    // NOTE: payload registers are reset too, since outData must read 0 out of reset.
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    head_data_q <= '0;
                    head_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    // NOTE: non-blocking assignments so every flop samples pre-edge values.
                    state_q     <= state_d;
                    in_ready_q  <= in_ready_d;
                    out_valid_q <= out_valid_d;
                    head_data_q <= head_data_d;
                    head_ctrl_q <= head_ctrl_d;
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end
        end else begin : g_single
            logic              out_valid_d;
            logic [DATA_W-1:0] head_data_d;
            logic [CTRL_W-1:0] head_ctrl_d;

            assign in_ready_w = reset & (~out_valid_q | outReady);

            always_comb begin
                out_valid_d = out_valid_q;
                head_data_d = head_data_q;
                head_ctrl_d = head_ctrl_q;
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    head_data_d = inData;
                    head_ctrl_d = inCtrl;
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
                if (flush) begin
                    out_valid_d = 1'b0;
                    head_data_d = head_data_q;
                    head_ctrl_d = head_ctrl_q;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_valid_q <= 1'b0;
                    head_data_q <= '0;
                    head_ctrl_q <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    head_data_q <= head_data_d;
                    head_ctrl_q <= head_ctrl_d;
                end
            end
        end
    endgenerate

    // Starvation counter: downstream ready but nothing to give it; saturates, ignores flush.
    always_comb begin
        bubble_d = bubble_q;
        if (outReady && !out_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-register instance,
// checked by a queue-based occupancy model plus vector tables and corner sequences.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [7:0]  data;
        logic [11:0] ctrl;
    } beat_t;

    typedef struct {
        bit          sel;
        bit          in_valid;
        logic [7:0]  in_data;
        logic [11:0] in_ctrl;
        bit          out_ready;
        bit          exp_valid;
        logic [7:0]  exp_data;
        logic [11:0] exp_ctrl;
        bit          exp_ready;
        logic [3:0]  exp_bubble;
    } vec_t;

    localparam int NV = 13;

    logic clk = 1'b0;
    logic reset;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_in_data, s_out_data;
    logic [11:0] s_in_ctrl, s_out_ctrl;
    logic [3:0]  s_bubble;

    logic        f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [7:0]  f_in_data, f_out_data;
    logic [11:0] f_in_ctrl, f_out_ctrl;
    logic [3:0]  f_bubble;

    int checks   = 0;
    int failures = 0;

    beat_t q_s[$];
    beat_t q_f[$];
    int    cnt_s, cnt_f;
    vec_t  vecs[NV];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(12), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .reset(reset), .flush(s_flush),
        .inValid(s_in_valid), .inReady(s_in_ready), .inData(s_in_data), .inCtrl(s_in_ctrl),
        .outValid(s_out_valid), .outReady(s_out_ready), .outData(s_out_data), .outCtrl(s_out_ctrl),
        .bubbleCount(s_bubble)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(12), .SKID(0), .CNT_W(4)) u_flop (
        .clk(clk), .reset(reset), .flush(f_flush),
        .inValid(f_in_valid), .inReady(f_in_ready), .inData(f_in_data), .inCtrl(f_in_ctrl),
        .outValid(f_out_valid), .outReady(f_out_ready), .outData(f_out_data), .outCtrl(f_out_ctrl),
        .bubbleCount(f_bubble)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int sel, input int v, input int d, input int c, input int r,
                                input int ev, input int ed, input int ec, input int er, input int eb);
        vec_t x;
        x.sel = sel[0]; x.in_valid = v[0]; x.in_data = 8'(d); x.in_ctrl = 12'(c);
        x.out_ready = r[0]; x.exp_valid = ev[0]; x.exp_data = 8'(ed); x.exp_ctrl = 12'(ec);
        x.exp_ready = er[0]; x.exp_bubble = 4'(eb);
        return x;
    endfunction

    // Idle cycles carry random junk on the data lines so nothing unsampled can leak out.
    task automatic drive_s(input int v, input int d, input int c, input int r, input int fl);
        s_in_valid  = v[0];
        s_in_data   = v[0] ? 8'(d) : 8'($urandom);
        s_in_ctrl   = v[0] ? 12'(c) : 12'($urandom);
        s_out_ready = r[0];
        s_flush     = fl[0];
    endtask

    task automatic drive_f(input int v, input int d, input int c, input int r, input int fl);
        f_in_valid  = v[0];
        f_in_data   = v[0] ? 8'(d) : 8'($urandom);
        f_in_ctrl   = v[0] ? 12'(c) : 12'($urandom);
        f_out_ready = r[0];
        f_flush     = fl[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the skid instance: a queue of at most two beats.
    logic  ms_ready, ms_valid;
    beat_t ms_beat;
    always @(negedge clk) begin
        if (!reset) begin
            q_s.delete();
            cnt_s = 0;
        end
        ms_ready = reset && (q_s.size() < 2);
        ms_valid = (q_s.size() != 0);
        check("skid_in_ready", s_in_ready, ms_ready);
        check("skid_out_valid", s_out_valid, ms_valid);
        check("skid_out_ctrl", s_out_ctrl, ms_valid ? q_s[0].ctrl : 12'h000);
        if (ms_valid) check("skid_out_data", s_out_data, q_s[0].data);
        check("skid_bubble", s_bubble, cnt_s);
        if (reset) begin
            if (s_out_ready && !ms_valid && cnt_s != 15) cnt_s++;
            if (s_flush) begin
                q_s.delete();
            end else begin
                if (ms_valid && s_out_ready) void'(q_s.pop_front());
                if (s_in_valid && ms_ready) begin
                    ms_beat.data = s_in_data;
                    ms_beat.ctrl = s_in_ctrl;
                    q_s.push_back(ms_beat);
                end
            end
        end
    end

    // Reference model for the single-register instance: capacity one, pass-through ready.
    logic  mf_ready, mf_valid;
    beat_t mf_beat;
    always @(negedge clk) begin
        if (!reset) begin
            q_f.delete();
            cnt_f = 0;
        end
        mf_valid = (q_f.size() != 0);
        mf_ready = reset && (!mf_valid || f_out_ready);
        check("flop_in_ready", f_in_ready, mf_ready);
        check("flop_out_valid", f_out_valid, mf_valid);
        check("flop_out_ctrl", f_out_ctrl, mf_valid ? q_f[0].ctrl : 12'h000);
        if (mf_valid) check("flop_out_data", f_out_data, q_f[0].data);
        check("flop_bubble", f_bubble, cnt_f);
        if (reset) begin
            if (f_out_ready && !mf_valid && cnt_f != 15) cnt_f++;
            if (f_flush) begin
                q_f.delete();
            end else begin
                if (mf_valid && f_out_ready) void'(q_f.pop_front());
                if (f_in_valid && mf_ready) begin
                    mf_beat.data = f_in_data;
                    mf_beat.ctrl = f_in_ctrl;
                    q_f.push_back(mf_beat);
                end
            end
        end
    end

    logic        a_valid, a_ready;
    logic [7:0]  a_data;
    logic [11:0] a_ctrl;
    logic [3:0]  a_bubble;

    initial begin
        // sel, in_valid, in_data, in_ctrl, out_ready | valid, data, ctrl, ready, bubble
        vecs[0]  = mk(0, 1, 8'h01, 12'h101, 1,  0, 8'h00, 12'h000, 1, 0);
        vecs[1]  = mk(0, 1, 8'h02, 12'h102, 1,  1, 8'h01, 12'h101, 1, 1);
        vecs[2]  = mk(0, 1, 8'h03, 12'h103, 1,  1, 8'h02, 12'h102, 1, 1);
        vecs[3]  = mk(0, 1, 8'h04, 12'h104, 1,  1, 8'h03, 12'h103, 1, 1);
        vecs[4]  = mk(0, 0, 8'h00, 12'h000, 1,  1, 8'h04, 12'h104, 1, 1);
        vecs[5]  = mk(0, 0, 8'h00, 12'h000, 1,  0, 8'h00, 12'h000, 1, 1);
        vecs[6]  = mk(1, 1, 8'h11, 12'h211, 1,  0, 8'h00, 12'h000, 1, 0);
        vecs[7]  = mk(1, 1, 8'h12, 12'h212, 0,  1, 8'h11, 12'h211, 0, 1);
        vecs[8]  = mk(1, 1, 8'h12, 12'h212, 1,  1, 8'h11, 12'h211, 1, 1);
        vecs[9]  = mk(1, 1, 8'h13, 12'h213, 0,  1, 8'h12, 12'h212, 0, 1);
        vecs[10] = mk(1, 1, 8'h13, 12'h213, 1,  1, 8'h12, 12'h212, 1, 1);
        vecs[11] = mk(1, 0, 8'h00, 12'h000, 1,  1, 8'h13, 12'h213, 1, 1);
        vecs[12] = mk(1, 0, 8'h00, 12'h000, 1,  0, 8'h00, 12'h000, 1, 1);

        reset = 1'b0;
        drive_s(0, 0, 0, 1, 0);
        drive_f(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", s_out_valid, 1'b0);
        check("rst_out_data", s_out_data, 8'h00);
        check("rst_out_ctrl", s_out_ctrl, 12'h000);
        check("rst_in_ready", s_in_ready, 1'b0);
        check("rst_bubble", s_bubble, 4'd0);
        check("rst_flop_in_ready", f_in_ready, 1'b0);
        tick();
        reset = 1'b1;

        // Streaming on the skid stage, then stall patterns on the single register.
        for (int i = 0; i < NV; i++) begin
            if (!vecs[i].sel) begin
                drive_s(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_ctrl, vecs[i].out_ready, 0);
                drive_f(0, 0, 0, 0, 0);
            end else begin
                drive_f(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_ctrl, vecs[i].out_ready, 0);
                drive_s(0, 0, 0, 0, 0);
            end
            @(negedge clk);
            if (!vecs[i].sel) begin
                a_valid = s_out_valid; a_ready = s_in_ready; a_data = s_out_data;
                a_ctrl = s_out_ctrl; a_bubble = s_bubble;
            end else begin
                a_valid = f_out_valid; a_ready = f_in_ready; a_data = f_out_data;
                a_ctrl = f_out_ctrl; a_bubble = f_bubble;
            end
            check($sformatf("vec%0d_out_valid", i), a_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_in_ready", i), a_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_out_ctrl", i), a_ctrl, vecs[i].exp_ctrl);
            check($sformatf("vec%0d_bubble", i), a_bubble, vecs[i].exp_bubble);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_out_data", i), a_data, vecs[i].exp_data);
            tick();
        end
        drive_f(0, 0, 0, 0, 0);

        // Backpressure fills the skid, then drains A, B, C in order.
        drive_s(1, 8'h0A, 12'h0AA, 0, 0); tick();
        drive_s(1, 8'h0B, 12'h0BB, 0, 0); tick();
        drive_s(1, 8'h0C, 12'h0CC, 0, 0);
        @(negedge clk);
        check("bp_full_in_ready", s_in_ready, 1'b0);
        check("bp_head_a", s_out_data, 8'h0A);
        tick();
        drive_s(1, 8'h0C, 12'h0CC, 1, 0); tick();
        @(negedge clk);
        check("bp_head_b", s_out_data, 8'h0B);
        check("bp_ready_again", s_in_ready, 1'b1);
        tick();
        drive_s(0, 0, 0, 1, 0);
        @(negedge clk);
        check("bp_head_c", s_out_data, 8'h0C);
        tick(); tick();

        // Flush from FULL with all-ones control: next cycle is a clean bubble.
        drive_s(1, 8'h0A, 12'hFFF, 0, 0); tick();
        drive_s(1, 8'h0B, 12'hFFF, 0, 0); tick();
        drive_s(1, 8'h0C, 12'hFFF, 0, 1); tick();
        drive_s(0, 0, 0, 1, 0);
        @(negedge clk);
        check("flush_out_valid", s_out_valid, 1'b0);
        check("flush_out_ctrl", s_out_ctrl, 12'h000);
        tick();
        // Flush in ONE with a beat firing on both sides: head leaves, new beat is dropped.
        drive_s(1, 8'h1D, 12'h01D, 1, 0); tick();
        drive_s(1, 8'h1E, 12'h01E, 1, 1); tick();
        drive_s(0, 0, 0, 1, 0);
        @(negedge clk);
        check("flush_one_out_valid", s_out_valid, 1'b0);
        tick();
        drive_f(1, 8'h31, 12'h031, 0, 0); tick();
        drive_f(1, 8'h32, 12'h032, 1, 1); tick();
        drive_f(0, 0, 0, 0, 0);
        @(negedge clk);
        check("flop_flush_out_valid", f_out_valid, 1'b0);
        check("flop_flush_out_ctrl", f_out_ctrl, 12'h000);
        tick();

        // Counter saturation; flush leaves it alone.
        drive_s(0, 0, 0, 1, 0);
        repeat (20) tick();
        @(negedge clk);
        check("sat_bubble", s_bubble, 4'hF);
        tick();
        drive_s(0, 0, 0, 1, 1); tick();
        drive_s(0, 0, 0, 1, 0);
        @(negedge clk);
        check("sat_after_flush", s_bubble, 4'hF);
        tick();

        // Fill both stages, then assert reset between clock edges.
        drive_s(1, 8'h61, 12'h161, 0, 0);
        drive_f(1, 8'h71, 12'h171, 0, 0); tick();
        drive_s(1, 8'h62, 12'h162, 0, 0); tick();
        drive_s(0, 0, 0, 0, 0);
        drive_f(0, 0, 0, 0, 0);
        @(negedge clk);
        check("pre_rst_full", s_in_ready, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", s_out_valid, 1'b0);
        check("async_out_ctrl", s_out_ctrl, 12'h000);
        check("async_in_ready", s_in_ready, 1'b0);
        check("async_out_data", s_out_data, 8'h00);
        check("async_bubble", s_bubble, 4'd0);
        check("async_flop_valid", f_out_valid, 1'b0);
        check("async_flop_in_ready", f_in_ready, 1'b0);
        tick();
        reset = 1'b1;
        drive_s(1, 8'h81, 12'h181, 1, 0); tick();
        drive_s(0, 0, 0, 1, 0);
        @(negedge clk);
        check("restart_out_data", s_out_data, 8'h81);
        check("restart_out_ctrl", s_out_ctrl, 12'h181);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
